// File: rtl/imem_boot_loader.sv
// Purpose: loads a word stream into instruction memory (16-bit word-count header, then words sent LSB first).
// Latency: a word is written in the cycle after its 4th byte is accepted, so each word takes at least 5 cycles.
// Backpressure: rx_ready is low during the write cycle and outside a session; bytes are taken only when rx_valid && rx_ready.
module imem_boot_loader #(
  parameter int ADDR_WIDTH = 12,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_waddr,
  output logic [31:0]           imem_wdata,
  output logic                  core_hold,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_t;

  // Largest legal word count: the whole memory. One extra bit is needed so
  // that a 16-bit address space (65536 words) can be represented.
  localparam logic [LEN_WIDTH:0] MAX_WORDS = {{LEN_WIDTH{1'b0}}, 1'b1} << ADDR_WIDTH;

  state_t                state;
  logic [7:0]            len_lo;
  logic [ADDR_WIDTH:0]   n_words;
  logic [1:0]            byte_idx;
  logic [23:0]           word_buf;
  logic                  accept;
  logic [LEN_WIDTH:0]    hdr_ext;
  logic [ADDR_WIDTH:0]   wl_inc;

  assign accept  = rx_valid && rx_ready;
  assign hdr_ext = {1'b0, rx_data, len_lo};
  assign wl_inc  = words_loaded + {{ADDR_WIDTH{1'b0}}, 1'b1};

  // Single FSM; every output is a register updated together with the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      rx_ready     <= 1'b0;
      imem_we      <= 1'b0;
      imem_waddr   <= '0;
      imem_wdata   <= '0;
      core_hold    <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
      byte_idx     <= '0;
      len_lo       <= '0;
      n_words      <= '0;
      word_buf     <= '0;
    end else begin
      case (state)
        // A new session may be opened from any idle-like state; the sticky
        // status flags and the count are cleared when it opens.
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state        <= S_LEN_LO;
            rx_ready     <= 1'b1;
            core_hold    <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
            byte_idx     <= '0;
          end
        end

        S_LEN_LO: begin
          if (accept) begin
            len_lo <= rx_data;
            state  <= S_LEN_HI;
          end
        end

        S_LEN_HI: begin
          if (accept) begin
            if (hdr_ext == '0) begin
              state     <= S_DONE;
              done      <= 1'b1;
              rx_ready  <= 1'b0;
              core_hold <= 1'b0;
            end else if (hdr_ext > MAX_WORDS) begin
              state     <= S_ERROR;
              error     <= 1'b1;
              rx_ready  <= 1'b0;
              core_hold <= 1'b0;
            end else begin
              state   <= S_DATA;
              n_words <= hdr_ext[ADDR_WIDTH:0];
            end
          end
        end

        // Bytes 0..2 are buffered; byte 3 completes the word and launches
        // the write directly, so the buffer never carries residue.
        S_DATA: begin
          if (accept) begin
            if (byte_idx == 2'd3) begin
              state      <= S_WRITE;
              rx_ready   <= 1'b0;
              imem_we    <= 1'b1;
              imem_waddr <= words_loaded[ADDR_WIDTH-1:0];
              imem_wdata <= {rx_data, word_buf};
              byte_idx   <= '0;
            end else begin
              case (byte_idx)
                2'd0:    word_buf[7:0]   <= rx_data;
                2'd1:    word_buf[15:8]  <= rx_data;
                default: word_buf[23:16] <= rx_data;
              endcase
              byte_idx <= byte_idx + 2'd1;
            end
          end
        end

        // The write lasts exactly one cycle; address/data then hold.
        S_WRITE: begin
          imem_we      <= 1'b0;
          words_loaded <= wl_inc;
          if (wl_inc == n_words) begin
            state     <= S_DONE;
            done      <= 1'b1;
            core_hold <= 1'b0;
          end else begin
            state    <= S_DATA;
            rx_ready <= 1'b1;
          end
        end

        default: begin
          state     <= S_IDLE;
          rx_ready  <= 1'b0;
          imem_we   <= 1'b0;
          core_hold <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: a cycle-by-cycle vector table for a clean two-word load,
// then directed sequences for gaps, empty header, oversize header, mid-session reset and start handling.
// Writes are captured into a queue and compared against hand-computed address/data pairs.
module tb_imem_boot_loader;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ready;
  logic          imem_we;
  logic [AW-1:0] imem_waddr;
  logic [31:0]   imem_wdata;
  logic          core_hold;
  logic          done;
  logic          error;
  logic [AW:0]   words_loaded;

  imem_boot_loader #(.ADDR_WIDTH(AW), .LEN_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .start(start),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .core_hold(core_hold), .done(done), .error(error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  // Packed view of all outputs: ready, we, addr, wdata, hold, done, error, count.
  logic [61:0] outs;
  assign outs = {rx_ready, imem_we, imem_waddr, imem_wdata, core_hold, done, error, words_loaded};

  function automatic logic [61:0] mk(input logic rdy, input logic we, input logic [AW-1:0] a,
                                     input logic [31:0] d, input logic h, input logic dn,
                                     input logic er, input logic [AW:0] wl);
    return {rdy, we, a, d, h, dn, er, wl};
  endfunction

  typedef struct {
    logic        st;
    logic        vld;
    logic [7:0]  dat;
    logic [61:0] exp;
  } vec_t;

  vec_t tbl [14];

  int tests = 0;
  int fails = 0;
  int viol  = 0;
  logic prev_we = 1'b0;
  logic [43:0] wq [$];

  // Capture every write strobe mid-cycle; flag back-to-back strobes.
  always @(negedge clk) begin
    if (imem_we) begin
      wq.push_back({imem_waddr, imem_wdata});
      if (prev_we) viol++;
    end
    prev_we = imem_we;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    logic ok;
    ok = 1'b0;
    rx_valid = 1'b1;
    rx_data  = b;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (rx_ready) ok = 1'b1;
      step();
    end
    check("rx_ready_wait", {63'd0, ok}, 64'd1);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    repeat (gap) step();
  endtask

  task automatic wait_end();
    for (int i = 0; i < 200 && !(done || error); i++) step();
    check("end_reached", {63'd0, done | error}, 64'd1);
  endtask

  logic [7:0] stream [10];

  initial begin
    stream = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h00, 8'h20, 8'h00};

    tbl[0]  = '{1'b1, 1'b0, 8'h00, mk(1, 0, 0, 32'h0,        1, 0, 0, 0)};
    tbl[1]  = '{1'b0, 1'b1, 8'h02, mk(1, 0, 0, 32'h0,        1, 0, 0, 0)};
    tbl[2]  = '{1'b0, 1'b1, 8'h00, mk(1, 0, 0, 32'h0,        1, 0, 0, 0)};
    tbl[3]  = '{1'b0, 1'b1, 8'h13, mk(1, 0, 0, 32'h0,        1, 0, 0, 0)};
    tbl[4]  = '{1'b0, 1'b1, 8'h00, mk(1, 0, 0, 32'h0,        1, 0, 0, 0)};
    tbl[5]  = '{1'b0, 1'b1, 8'h00, mk(1, 0, 0, 32'h0,        1, 0, 0, 0)};
    tbl[6]  = '{1'b0, 1'b1, 8'h00, mk(0, 1, 0, 32'h13,       1, 0, 0, 0)};
    tbl[7]  = '{1'b0, 1'b1, 8'hB3, mk(1, 0, 0, 32'h13,       1, 0, 0, 1)};
    tbl[8]  = '{1'b0, 1'b1, 8'hB3, mk(1, 0, 0, 32'h13,       1, 0, 0, 1)};
    tbl[9]  = '{1'b0, 1'b1, 8'h00, mk(1, 0, 0, 32'h13,       1, 0, 0, 1)};
    tbl[10] = '{1'b0, 1'b1, 8'h20, mk(1, 0, 0, 32'h13,       1, 0, 0, 1)};
    tbl[11] = '{1'b0, 1'b1, 8'h00, mk(0, 1, 1, 32'h002000B3, 1, 0, 0, 1)};
    tbl[12] = '{1'b0, 1'b0, 8'h00, mk(0, 0, 1, 32'h002000B3, 0, 1, 0, 2)};
    tbl[13] = '{1'b0, 1'b1, 8'hFF, mk(0, 0, 1, 32'h002000B3, 0, 1, 0, 2)};

    reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) step();
    check("reset_state", {2'b0, outs}, 64'd0);
    reset = 1'b0;

    // Test 1: back-to-back two-word load, checked every cycle.
    wq.delete();
    for (int i = 0; i < 14; i++) begin
      start    = tbl[i].st;
      rx_valid = tbl[i].vld;
      rx_data  = tbl[i].dat;
      step();
      check($sformatf("t1_vec%0d", i), {2'b0, outs}, {2'b0, tbl[i].exp});
    end
    start = 1'b0; rx_valid = 1'b0;
    check("t1_nwrites", 64'(wq.size()), 64'd2);
    check("t1_w0", 64'(wq[0]), {20'd0, 12'd0, 32'h00000013});
    check("t1_w1", 64'(wq[1]), {20'd0, 12'd1, 32'h002000B3});

    // Test 2: same stream with random gaps.
    wq.delete();
    pulse_start();
    for (int i = 0; i < 10; i++) send_byte(stream[i], $urandom_range(0, 5));
    wait_end();
    check("t2_nwrites", 64'(wq.size()), 64'd2);
    check("t2_w0", 64'(wq[0]), {20'd0, 12'd0, 32'h00000013});
    check("t2_w1", 64'(wq[1]), {20'd0, 12'd1, 32'h002000B3});
    check("t2_done_wl", {50'd0, done, error, words_loaded}, {50'd0, 1'b1, 1'b0, 13'd2});

    // Test 3: empty header goes straight to DONE.
    wq.delete();
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    check("t3_done_now", {50'd0, done, core_hold, words_loaded}, {50'd0, 1'b1, 1'b0, 13'd0});
    repeat (3) step();
    check("t3_nwrites", 64'(wq.size()), 64'd0);

    // Test 4: oversize header errors out; a new session clears it.
    wq.delete();
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h10, 0);
    check("t4_error", {60'd0, error, done, rx_ready, core_hold}, {60'd0, 4'b1000});
    repeat (2) step();
    check("t4_nwrites", 64'(wq.size()), 64'd0);
    pulse_start();
    check("t4_err_clear", {62'd0, error, rx_ready}, {62'd0, 2'b01});
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h78, 0); send_byte(8'h56, 0); send_byte(8'h34, 0); send_byte(8'h12, 0);
    wait_end();
    check("t4_after", {61'd0, done, error, imem_we}, {61'd0, 3'b100});
    check("t4_nwrites2", 64'(wq.size()), 64'd1);
    check("t4_w0", 64'(wq[0]), {20'd0, 12'd0, 32'h12345678});

    // Test 5: reset in the middle of word 3, then a clean reload.
    wq.delete();
    pulse_start();
    send_byte(8'h04, 0);
    send_byte(8'h00, 0);
    for (int i = 0; i < 14; i++) send_byte(8'(8'h40 + i), 1);
    reset = 1'b1;
    step();
    check("t5_reset_outs", {2'b0, outs}, 64'd0);
    reset = 1'b0;
    check("t5_nwrites", 64'(wq.size()), 64'd3);
    check("t5_w2", 64'(wq[2]), {20'd0, 12'd2, 32'h4B4A4948});
    wq.delete();
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'hAA, 0); send_byte(8'hBB, 0); send_byte(8'hCC, 0); send_byte(8'hDD, 0);
    wait_end();
    check("t5_nwrites2", 64'(wq.size()), 64'd1);
    check("t5_w0", 64'(wq[0]), {20'd0, 12'd0, 32'hDDCCBBAA});

    // Test 6: start ignored during DATA, honoured in DONE.
    wq.delete();
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h44, 0);
    send_byte(8'h33, 0);
    pulse_start();
    check("t6_start_ignored", {48'd0, core_hold, rx_ready, done, words_loaded},
          {48'd0, 1'b1, 1'b1, 1'b0, 13'd0});
    send_byte(8'h22, 0); send_byte(8'h11, 0);
    send_byte(8'h88, 2); send_byte(8'h77, 0); send_byte(8'h66, 3); send_byte(8'h55, 0);
    wait_end();
    check("t6_nwrites", 64'(wq.size()), 64'd2);
    check("t6_w0", 64'(wq[0]), {20'd0, 12'd0, 32'h11223344});
    check("t6_w1", 64'(wq[1]), {20'd0, 12'd1, 32'h55667788});
    check("t6_wl", 64'(words_loaded), 64'd2);
    pulse_start();
    check("t6_restart", {48'd0, done, rx_ready, core_hold, words_loaded},
          {48'd0, 1'b0, 1'b1, 1'b1, 13'd0});

    check("we_never_consecutive", 64'(viol), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
